// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : stopwatch_ctrl                                               |
// | Description : Run/stop/split controller with prescaler and BCD digit chain.|
// |               Optional macro STOPWATCH_SATURATE_EN: saturate at all-9s     |
// |               with sticky OVF (default: wrap with one-cycle OVF pulse).    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module stopwatch_ctrl #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 10
) (
  input  logic                  CK,
  input  logic                  AR,
  input  logic                  SS,
  input  logic                  LAP,
  input  logic                  CLR,
  output logic                  RUN,
  output logic                  TICK,
  output logic [4*DIGITS-1:0]   Q,
  output logic [4*DIGITS-1:0]   DISP,
  output logic                  OVF
);

  localparam int              c_PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [c_PW-1:0] c_PRESC_LAST = c_PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_HOLD  = 2'd2,
    S_SPLIT = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_PW-1:0]     r_presc;
  logic [4*DIGITS-1:0] r_q;
  logic [4*DIGITS-1:0] r_disp;
  logic                r_ovf;

  logic                w_running;
  logic                w_presc_last;
  logic                w_tick;
  logic                w_ovf_evt;
  logic [DIGITS-1:0]   w_is9;
  logic [DIGITS-1:0]   w_inc;
  logic [4*DIGITS-1:0] w_q_inc;
  logic [4*DIGITS-1:0] w_q_nxt;

  always_ff @(posedge CK or posedge AR) begin
    if (AR) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // CLR outranks SS, which outranks LAP
  always_comb begin
    w_state_nxt = r_state;
    if (CLR) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (SS) w_state_nxt = S_RUN;
        S_RUN:   if (SS) w_state_nxt = S_HOLD;
                 else if (LAP) w_state_nxt = S_SPLIT;
        S_SPLIT: if (SS) w_state_nxt = S_HOLD;
                 else if (LAP) w_state_nxt = S_RUN;
        S_HOLD:  if (SS) w_state_nxt = S_RUN;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign w_running    = (r_state == S_RUN) || (r_state == S_SPLIT);
  assign w_presc_last = (r_presc == c_PRESC_LAST);

`ifdef STOPWATCH_SATURATE_EN
  assign w_tick = w_running & w_presc_last & ~r_ovf;
`else
  assign w_tick = w_running & w_presc_last;
`endif

  // Ripple-carry enables: digit k advances when all lower digits are 9
  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    assign w_is9[k] = (r_q[4*k +: 4] == 4'd9);
    if (k == 0) begin : g_lsd
      assign w_inc[k] = w_tick;
    end else begin : g_carry
      assign w_inc[k] = w_inc[k-1] & w_is9[k-1];
    end
    assign w_q_inc[4*k +: 4] = !w_inc[k] ? r_q[4*k +: 4] :
                               (w_is9[k] ? 4'd0 : r_q[4*k +: 4] + 4'd1);
  end

  assign w_ovf_evt = w_tick & (&w_is9);

`ifdef STOPWATCH_SATURATE_EN
  assign w_q_nxt = w_ovf_evt ? r_q : w_q_inc;
`else
  assign w_q_nxt = w_q_inc;
`endif

  always_ff @(posedge CK or posedge AR) begin
    if (AR) begin
      r_q     <= '0;
      r_disp  <= '0;
      r_presc <= '0;
      r_ovf   <= 1'b0;
    end else if (CLR) begin
      r_q     <= '0;
      r_disp  <= '0;
      r_presc <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_q <= w_q_nxt;
      // Display freezes only while remaining in SPLIT; entering SPLIT captures the advanced count
      if (!((r_state == S_SPLIT) && (w_state_nxt == S_SPLIT))) begin
        r_disp <= w_q_nxt;
      end
      if (w_running) begin
        r_presc <= w_presc_last ? '0 : r_presc + c_PW'(1);
      end
`ifdef STOPWATCH_SATURATE_EN
      r_ovf <= r_ovf | w_ovf_evt;
`else
      r_ovf <= w_ovf_evt;
`endif
    end
  end

  assign RUN  = w_running;
  assign TICK = w_tick;
  assign Q    = r_q;
  assign DISP = r_disp;
  assign OVF  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_stopwatch_ctrl                                            |
// | Description : Bench for stopwatch_ctrl against an integer-count model.     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_stopwatch_ctrl;
  localparam int D0 = 4, P0 = 10, D1 = 2, P1 = 1;
  localparam int ST_IDLE = 0, ST_RUN = 1, ST_HOLD = 2, ST_SPLIT = 3;
`ifdef STOPWATCH_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic CK = 1'b0, AR = 1'b1;
  logic ss0 = 1'b0, lap0 = 1'b0, clr0 = 1'b0;
  logic ss1 = 1'b0, lap1 = 1'b0, clr1 = 1'b0;
  logic run0, tick0, ovf0, run1, tick1, ovf1;
  logic [4*D0-1:0] q0, disp0;
  logic [4*D1-1:0] q1, disp1;

  stopwatch_ctrl #(.DIGITS(D0), .PRESCALE(P0)) u_dut0 (
    .CK(CK), .AR(AR), .SS(ss0), .LAP(lap0), .CLR(clr0),
    .RUN(run0), .TICK(tick0), .Q(q0), .DISP(disp0), .OVF(ovf0));

  stopwatch_ctrl #(.DIGITS(D1), .PRESCALE(P1)) u_dut1 (
    .CK(CK), .AR(AR), .SS(ss1), .LAP(lap1), .CLR(clr1),
    .RUN(run1), .TICK(tick1), .Q(q1), .DISP(disp1), .OVF(ovf1));

  always #5 CK = ~CK;

  int n_checks = 0;
  int n_fail   = 0;

  // Model keeps the count as a plain integer; BCD is derived only for comparison
  int m_state[2], m_cnt[2], m_presc[2], m_disp[2];
  bit m_ovf[2];

  function automatic logic [31:0] to_bcd(input int v, input int nd);
    logic [31:0] r;
    int pw;
    r  = '0;
    pw = 1;
    for (int k = 0; k < nd; k++) begin
      r[4*k +: 4] = 4'((v / pw) % 10);
      pw = pw * 10;
    end
    return r;
  endfunction

  function automatic bit model_running(input int i);
    return (m_state[i] == ST_RUN) || (m_state[i] == ST_SPLIT);
  endfunction

  function automatic bit model_tick(input int i, input int np);
    return model_running(i) && (m_presc[i] == np - 1) && !(SAT && m_ovf[i]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_state[i] = ST_IDLE; m_cnt[i] = 0; m_presc[i] = 0; m_disp[i] = 0; m_ovf[i] = 1'b0;
    end
  endtask

  task automatic model_step(input int i, input int nd, input int np,
                            input bit s, input bit l, input bit c);
    bit running, t, oevt;
    int mx, ncnt, nst;
    running = model_running(i);
    t       = model_tick(i, np);
    mx      = 10 ** nd;
    if (c) begin
      m_state[i] = ST_IDLE; m_cnt[i] = 0; m_presc[i] = 0; m_disp[i] = 0; m_ovf[i] = 1'b0;
      return;
    end
    oevt = t && (m_cnt[i] == mx - 1);
    ncnt = m_cnt[i];
    if (t) ncnt = (SAT && oevt) ? m_cnt[i] : (m_cnt[i] + 1) % mx;
    if (running) m_presc[i] = (m_presc[i] + 1) % np;
    m_ovf[i] = SAT ? (m_ovf[i] || oevt) : oevt;
    nst = m_state[i];
    case (m_state[i])
      ST_IDLE:  if (s) nst = ST_RUN;
      ST_RUN:   if (s) nst = ST_HOLD; else if (l) nst = ST_SPLIT;
      ST_SPLIT: if (s) nst = ST_HOLD; else if (l) nst = ST_RUN;
      ST_HOLD:  if (s) nst = ST_RUN;
      default:  nst = ST_IDLE;
    endcase
    if (!(m_state[i] == ST_SPLIT && nst == ST_SPLIT)) m_disp[i] = ncnt;
    m_cnt[i]   = ncnt;
    m_state[i] = nst;
  endtask

  // Entered and left on a falling edge; drives one clock of pulses into both DUTs
  task automatic cycle(input logic s0, input logic l0, input logic c0,
                       input logic s1, input logic l1, input logic c1);
    logic [31:0] eq0, ed0, eq1, ed1;
    bit et0, et1;
    ss0 = s0; lap0 = l0; clr0 = c0;
    ss1 = s1; lap1 = l1; clr1 = c1;
    et0 = model_tick(0, P0);
    et1 = model_tick(1, P1);
    n_checks++;
    if (tick0 !== et0) begin n_fail++; $display("FAIL tick0: got %b expected %b t=%0t", tick0, et0, $time); end
    n_checks++;
    if (tick1 !== et1) begin n_fail++; $display("FAIL tick1: got %b expected %b t=%0t", tick1, et1, $time); end
    model_step(0, D0, P0, s0, l0, c0);
    model_step(1, D1, P1, s1, l1, c1);
    @(posedge CK);
    @(negedge CK);
    ss0 = 1'b0; lap0 = 1'b0; clr0 = 1'b0;
    ss1 = 1'b0; lap1 = 1'b0; clr1 = 1'b0;
    eq0 = to_bcd(m_cnt[0], D0);  ed0 = to_bcd(m_disp[0], D0);
    eq1 = to_bcd(m_cnt[1], D1);  ed1 = to_bcd(m_disp[1], D1);
    n_checks++;
    if (q0 !== eq0[4*D0-1:0]) begin n_fail++; $display("FAIL q0: got %h expected %h t=%0t", q0, eq0[4*D0-1:0], $time); end
    n_checks++;
    if (disp0 !== ed0[4*D0-1:0]) begin n_fail++; $display("FAIL disp0: got %h expected %h t=%0t", disp0, ed0[4*D0-1:0], $time); end
    n_checks++;
    if (run0 !== model_running(0)) begin n_fail++; $display("FAIL run0: got %b expected %b t=%0t", run0, model_running(0), $time); end
    n_checks++;
    if (ovf0 !== m_ovf[0]) begin n_fail++; $display("FAIL ovf0: got %b expected %b t=%0t", ovf0, m_ovf[0], $time); end
    n_checks++;
    if (q1 !== eq1[4*D1-1:0]) begin n_fail++; $display("FAIL q1: got %h expected %h t=%0t", q1, eq1[4*D1-1:0], $time); end
    n_checks++;
    if (disp1 !== ed1[4*D1-1:0]) begin n_fail++; $display("FAIL disp1: got %h expected %h t=%0t", disp1, ed1[4*D1-1:0], $time); end
    n_checks++;
    if (run1 !== model_running(1)) begin n_fail++; $display("FAIL run1: got %b expected %b t=%0t", run1, model_running(1), $time); end
    n_checks++;
    if (ovf1 !== m_ovf[1]) begin n_fail++; $display("FAIL ovf1: got %b expected %b t=%0t", ovf1, m_ovf[1], $time); end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    AR = 1'b1;
    @(negedge CK);
    n_checks++;
    if (q0 !== '0 || disp0 !== '0 || run0 !== 1'b0 || tick0 !== 1'b0 || ovf0 !== 1'b0) begin
      n_fail++; $display("FAIL reset_state: got q=%h disp=%h run=%b tick=%b ovf=%b expected all zero", q0, disp0, run0, tick0, ovf0);
    end
    AR = 1'b0;
    model_reset();
    idle(50);
    n_checks++;
    if (q0 !== 16'h0000 || run0 !== 1'b0) begin n_fail++; $display("FAIL reset_idle50: got q=%h run=%b expected 0000/0", q0, run0); end
  endtask

  task automatic test_count();
    cycle(1, 0, 0, 0, 0, 0);
    idle(100);
    n_checks++;
    if (q0 !== 16'h0010 || disp0 !== 16'h0010 || run0 !== 1'b1) begin
      n_fail++; $display("FAIL count100: got q=%h disp=%h run=%b expected 0010/0010/1", q0, disp0, run0);
    end
  endtask

  task automatic test_split();
    int guard;
    guard = 0;
    while (m_cnt[0] != 37 && guard < 1000) begin cycle(0, 0, 0, 0, 0, 0); guard++; end
    cycle(0, 1, 0, 0, 0, 0);
    guard = 0;
    while (m_cnt[0] != 40 && guard < 1000) begin cycle(0, 0, 0, 0, 0, 0); guard++; end
    n_checks++;
    if (disp0 !== 16'h0037 || q0 !== 16'h0040) begin
      n_fail++; $display("FAIL split_hold: got disp=%h q=%h expected 0037/0040", disp0, q0);
    end
    cycle(0, 1, 0, 0, 0, 0);
    n_checks++;
    if (disp0 !== 16'h0040) begin n_fail++; $display("FAIL split_resume: got disp=%h expected 0040", disp0); end
  endtask

  task automatic test_hold();
    int guard, p_saved, n;
    cycle(0, 0, 1, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    guard = 0;
    while (m_cnt[0] != 123 && guard < 2000) begin cycle(0, 0, 0, 0, 0, 0); guard++; end
    idle($urandom_range(0, 8));
    cycle(1, 0, 0, 0, 0, 0);
    p_saved = m_presc[0];
    idle(200);
    n_checks++;
    if (q0 !== 16'h0123 || run0 !== 1'b0) begin n_fail++; $display("FAIL hold200: got q=%h run=%b expected 0123/0", q0, run0); end
    cycle(1, 0, 0, 0, 0, 0);
    n = 0;
    while (tick0 !== 1'b1 && n < 20) begin cycle(0, 0, 0, 0, 0, 0); n++; end
    n_checks++;
    if (n != P0 - 1 - p_saved) begin n_fail++; $display("FAIL hold_resume: got %0d cycles to tick expected %0d", n, P0 - 1 - p_saved); end
  endtask

  task automatic test_clr_ss();
    idle(15);
    cycle(1, 0, 1, 0, 0, 0);
    n_checks++;
    if (q0 !== 16'h0000 || run0 !== 1'b0 || disp0 !== 16'h0000) begin
      n_fail++; $display("FAIL clr_ss: got q=%h disp=%h run=%b expected 0000/0000/0", q0, disp0, run0);
    end
    idle(12);
  endtask

  task automatic test_async_reset();
    cycle(1, 0, 0, 1, 0, 0);
    idle(25);
    model_step(0, D0, P0, 0, 0, 0);
    model_step(1, D1, P1, 0, 0, 0);
    @(posedge CK);
    #2 AR = 1'b1;
    #1;
    n_checks++;
    if (q0 !== '0 || disp0 !== '0 || run0 !== 1'b0 || tick0 !== 1'b0 || ovf0 !== 1'b0 || q1 !== '0 || run1 !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: got q0=%h disp0=%h run0=%b tick0=%b q1=%h run1=%b expected zeros", q0, disp0, run0, tick0, q1, run1);
    end
    model_reset();
    @(negedge CK);
    AR = 1'b0;
  endtask

  task automatic test_overflow();
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 1, 0, 0);
    idle(99);
    n_checks++;
    if (q1 !== 8'h99 || ovf1 !== 1'b0) begin n_fail++; $display("FAIL ovf_pre: got q1=%h ovf1=%b expected 99/0", q1, ovf1); end
    idle(1);
`ifdef STOPWATCH_SATURATE_EN
    n_checks++;
    if (q1 !== 8'h99 || ovf1 !== 1'b1) begin n_fail++; $display("FAIL ovf_edge: got q1=%h ovf1=%b expected 99/1", q1, ovf1); end
    idle(3);
    n_checks++;
    if (q1 !== 8'h99 || ovf1 !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got q1=%h ovf1=%b expected 99/1", q1, ovf1); end
`else
    n_checks++;
    if (q1 !== 8'h00 || ovf1 !== 1'b1) begin n_fail++; $display("FAIL ovf_edge: got q1=%h ovf1=%b expected 00/1", q1, ovf1); end
    idle(1);
    n_checks++;
    if (q1 !== 8'h01 || ovf1 !== 1'b0) begin n_fail++; $display("FAIL ovf_pulse_end: got q1=%h ovf1=%b expected 01/0", q1, ovf1); end
`endif
    cycle(0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      cycle($urandom_range(0, 19) == 0, $urandom_range(0, 14) == 0, $urandom_range(0, 149) == 0,
            $urandom_range(0, 19) == 0, $urandom_range(0, 14) == 0, $urandom_range(0, 149) == 0);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_overflow();
    test_count();
    test_split();
    test_hold();
    test_clr_ss();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
